// File: rtl/cordic_sched.sv
`timescale 1ns/1ps
// Shares one pipelined cordic sin/cos core between NREQ requesters and returns tagged results.
// Build option: define CORDIC_RR_EN for round-robin arbitration (default is fixed priority).
module cordic_sched #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int LAT       = 16,
    parameter int XIN_SCALE = 19430
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_angle,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 drain,
    output logic [31:0]          cordic_angle,
    output logic [15:0]          cordic_xin,
    output logic [15:0]          cordic_yin,
    input  logic [16:0]          cordic_xout,
    input  logic [16:0]          cordic_yout,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [16:0]          rsp_cos,
    output logic [16:0]          rsp_sin,
    output logic [4:0]           inflight,
    output logic                 idle
);

    // state    | meaning
    // ST_IDLE  | nothing in flight, grants allowed
    // ST_RUN   | issuing and/or waiting for results
    // ST_DRAIN | grants blocked until the pipeline is empty
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic           accept_ok;
    logic           accept;
    logic           retire;
    logic [31:0]    gnt_angle;
    logic [IDW:0]   tag_pipe [0:LAT];

`ifdef CORDIC_RR_EN
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_sel;
    int             rr_idx;

    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        rr_idx  = 0;
        rr_sel  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = int'(rr_ptr) + i;
            if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
            rr_sel = IDW'(rr_idx);
            if (!gnt_any && req_valid[rr_sel]) begin
                gnt_any = 1'b1;
                gnt_id  = rr_sel;
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= gnt_id;
        end
    end
`else
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(i);
            end
        end
    end
`endif

    // rst_n gates the grant so req_ready reads zero while reset is held
    assign accept_ok = rst_n && (state != ST_DRAIN) && !drain;
    assign accept    = gnt_any && accept_ok;
    assign req_ready = accept ? (NREQ'(1) << gnt_id) : '0;
    assign retire    = tag_pipe[LAT-1][IDW];

    always_comb begin
        gnt_angle = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == gnt_id) gnt_angle = req_angle[32*k +: 32];
        end
    end

    assign cordic_xin = 16'(XIN_SCALE);
    assign cordic_yin = 16'd0;
    assign idle       = (state == ST_IDLE);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cordic_angle <= '0;
        end else if (accept) begin
            cordic_angle <= gnt_angle;
        end
    end

    // Stage 0 sits beside cordic_angle; stages 1..LAT track the core's registers.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= accept ? {1'b1, gnt_id} : '0;
            for (int i = 1; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_cos   <= '0;
            rsp_sin   <= '0;
        end else begin
            rsp_valid <= tag_pipe[LAT][IDW];
            if (tag_pipe[LAT][IDW]) begin
                rsp_id  <= tag_pipe[LAT][IDW-1:0];
                rsp_cos <= cordic_xout;
                rsp_sin <= cordic_yout;
            end
        end
    end

    // Counted out when the result leaves the core, one clock before rsp_valid,
    // so a full pipeline holds exactly LAT.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   inflight <= inflight + 5'd1;
                2'b01:   inflight <= inflight - 5'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!drain && (|req_valid)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (drain) begin
                    state_nxt = ST_DRAIN;
                end else if ((inflight == 5'd0) && !(|req_valid)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if ((inflight == 5'd0) && !tag_pipe[LAT][IDW]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
